// File: rtl/patch_stream_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// patch_stream_sequencer_pkg : shared state encoding, frame defaults, log2
// Revision : 1.0
// ============================================================================
package patch_stream_sequencer_pkg;

    localparam int DEF_IMAGE_WIDTH  = 640;
    localparam int DEF_IMAGE_HEIGHT = 480;
    localparam int DEF_FRAME_WIDTH  = 800;
    localparam int DEF_FRAME_HEIGHT = 525;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ceiling log2: bits needed to hold values 0..n-1.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/patch_stream_sequencer_raster_counter.sv
`default_nettype none
// ============================================================================
// raster_counter : frame raster position (vcnt, hcnt) with advance and last flag
// Revision : 1.0
// ============================================================================
module raster_counter
    import patch_stream_sequencer_pkg::*;
#(
    parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
    parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
    parameter int V_BITW       = 10,
    parameter int H_BITW       = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              advance_i,
    output logic [V_BITW-1:0] vcnt_o,
    output logic [H_BITW-1:0] hcnt_o,
    output logic              last_o
);

    localparam logic [V_BITW-1:0] V_LAST = V_BITW'(FRAME_HEIGHT - 1);
    localparam logic [H_BITW-1:0] H_LAST = H_BITW'(FRAME_WIDTH - 1);

    generate
        if (log2(FRAME_HEIGHT) > V_BITW || log2(FRAME_WIDTH) > H_BITW) begin : g_width_check
            $error("raster_counter: coordinate widths cannot hold the frame size");
        end
    endgenerate

    logic [V_BITW-1:0] vcnt_q, vcnt_d;
    logic [H_BITW-1:0] hcnt_q, hcnt_d;

    always_comb begin
        vcnt_d = vcnt_q;
        hcnt_d = hcnt_q;
        if (advance_i) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vcnt_q <= '0;
            hcnt_q <= '0;
        end else begin
            vcnt_q <= vcnt_d;
            hcnt_q <= hcnt_d;
        end
    end

    assign vcnt_o = vcnt_q;
    assign hcnt_o = hcnt_q;
    assign last_o = (vcnt_q == V_LAST) && (hcnt_q == H_LAST);

endmodule
`default_nettype wire

// File: rtl/patch_stream_sequencer.sv
`default_nettype none
// ============================================================================
// patch_stream_sequencer : raster walker feeding the sliding-window extractor
// Revision : 1.0
// ============================================================================
module patch_stream_sequencer
    import patch_stream_sequencer_pkg::*;
#(
    parameter int BIT_WIDTH    = 8,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
    parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
    parameter int V_BITW       = 10,
    // 10 bits are needed to hold FRAME_WIDTH-1 = 799
    parameter int H_BITW       = 10,
    parameter int FCNT_BITW    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 cont_i,
    input  logic [BIT_WIDTH-1:0] s_pixel_i,
    input  logic                 s_sof_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic                 m_ready_i,
    output logic [BIT_WIDTH-1:0] pe_pixel_o,
    output logic [V_BITW-1:0]    pe_vcnt_o,
    output logic [H_BITW-1:0]    pe_hcnt_o,
    output logic                 pe_enable_o,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic [FCNT_BITW-1:0] frame_cnt_o,
    output logic                 err_sync_o
);

    localparam logic [V_BITW-1:0] IMG_V_END = V_BITW'(IMAGE_HEIGHT);
    localparam logic [H_BITW-1:0] IMG_H_END = H_BITW'(IMAGE_WIDTH);

    state_t            state_q, state_d;
    logic [V_BITW-1:0] vcnt;
    logic [H_BITW-1:0] hcnt;
    logic              last_pos, active, running, step, at_origin;

    raster_counter #(
        .FRAME_HEIGHT (FRAME_HEIGHT),
        .FRAME_WIDTH  (FRAME_WIDTH),
        .V_BITW       (V_BITW),
        .H_BITW       (H_BITW)
    ) u_raster (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .advance_i (step),
        .vcnt_o    (vcnt),
        .hcnt_o    (hcnt),
        .last_o    (last_pos)
    );

    // Blanking positions advance without waiting on upstream data.
    assign running   = (state_q == ST_RUN);
    assign active    = (vcnt < IMG_V_END) && (hcnt < IMG_H_END);
    assign at_origin = (vcnt == '0) && (hcnt == '0);
    assign step      = running && m_ready_i && (active ? s_valid_i : 1'b1);
    assign s_ready_o = running && m_ready_i && active;
    assign busy_o    = running;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  if (step && last_pos && !cont_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    logic [BIT_WIDTH-1:0] pe_pixel_q;
    logic [V_BITW-1:0]    pe_vcnt_q;
    logic [H_BITW-1:0]    pe_hcnt_q;
    logic                 pe_enable_q, frame_done_q, err_sync_q;
    logic [FCNT_BITW-1:0] frame_cnt_q;

    // Coordinates hold while stalled so the extractor sees stable inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pe_pixel_q   <= '0;
            pe_vcnt_q    <= '0;
            pe_hcnt_q    <= '0;
            pe_enable_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            err_sync_q   <= 1'b0;
        end else begin
            pe_enable_q  <= step;
            frame_done_q <= step && last_pos;
            if (step) begin
                pe_pixel_q <= active ? s_pixel_i : '0;
                pe_vcnt_q  <= vcnt;
                pe_hcnt_q  <= hcnt;
            end
            if (step && last_pos) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (step && active && (s_sof_i != at_origin)) err_sync_q <= 1'b1;
        end
    end

    assign pe_pixel_o   = pe_pixel_q;
    assign pe_vcnt_o    = pe_vcnt_q;
    assign pe_hcnt_o    = pe_hcnt_q;
    assign pe_enable_o  = pe_enable_q;
    assign frame_done_o = frame_done_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign err_sync_o   = err_sync_q;

endmodule
`default_nettype wire
